dphy_lane_tx_seq: RTL and testbench
===================================

Name: dphy_lane_tx_seq

Overview:
Parametrised per-lane D-PHY transmit sequencer that sits in front of the lane SerDes and the LP drivers. It generates the complete LP-11 → LP-01 → LP-00 → HS-zero → SYNC → payload → HS-trail → LP-11 burst. Word width (bytes per word) and timing counter width are parameters, and all D-PHY timings are runtime-programmable. Word-rate outputs feed the lane serializer data/tristate inputs and the LP output pins directly.

Parameters:
g_bytes, 1, bytes per word; serdes_d_o width is 8*g_bytes; legal values are 1, 2, 4.
g_tcnt_bits, 8, width of each timing input and of the internal down-counter.
g_sync, 8'hB8, HS sync byte; bit 0 is transmitted first.

Ports:
clk_word_i  in  1  word-rate clock (serializer CLKDIV domain)
rst_a_i  in  1  asynchronous reset, active-high
hs_req_i  in  1  request/continue HS burst
data_i  in  8*g_bytes  payload word; bit 0 transmitted first
hs_ready_o  out  1  payload word accepted this cycle
busy_o  out  1  sequencer not in IDLE
t_lpx_i  in  g_tcnt_bits  LP-01 duration, in words
t_hs_prep_i  in  g_tcnt_bits  LP-00 duration
t_hs_zero_i  in  g_tcnt_bits  HS-zero duration
t_hs_trail_i  in  g_tcnt_bits  HS-trail duration
t_hs_exit_i  in  g_tcnt_bits  LP-11 hold after trail
serdes_d_o  out  8*g_bytes  word to serializer
hs_tq_o  out  1  1 = HS driver tristated (serializer T input)
lp_oe_n_o  out  1  0 = LP drivers enabled
lp_p_o  out  1  LP Dp level
lp_n_o  out  1  LP Dn level

Behaviour:
- All outputs are registered. Reset is asynchronous and active-high. On reset, outputs take these values: serdes_d_o=0, hs_tq_o=1, lp_oe_n_o=0, lp_p_o=1, lp_n_o=1, hs_ready_o=0, busy_o=0, state=IDLE.
- State duration: each timed state lasts max(t,1) cycles. The timing inputs are latched on the cycle IDLE exits, so changes during a burst have no effect until the next burst.
- States and outputs:
  - IDLE: LP-11. Go to LPX when hs_req_i=1.
  - LPX: LP-01 (p=0, n=1), lp_oe_n_o=0, hs_tq_o=1. Go to PREP when the timer expires.
  - PREP: LP-00. Go to ZERO.
  - ZERO: lp_oe_n_o=1, hs_tq_o=0, serdes_d_o=0. Go to SYNC.
  - SYNC: exactly 1 cycle. serdes_d_o = g_sync << 8*(g_bytes-1); the low bytes are 0 and act as extra HS-zero. If hs_req_i=1, go to DATA, otherwise go to TRAIL.
  - DATA: hs_ready_o=1 while hs_req_i=1. data_i is captured on the same edge and appears on serdes_d_o one cycle later. Leave for TRAIL on the first cycle with hs_req_i=0; hs_ready_o=0 in that cycle and no word is accepted.
  - TRAIL: serdes_d_o = all bits equal to the inverse of the MSB of the last transmitted word (SYNC or DATA); hs_tq_o=0. Go to EXIT.
  - EXIT: hs_tq_o=1, lp_oe_n_o=0, LP-11. Go to IDLE when the timer expires.
- busy_o=1 in every state except IDLE.
- The payload stream has no gaps. The only way to end a burst is to deassert hs_req_i.
- hs_req_i is ignored from LPX through ZERO, and in TRAIL and EXIT; a started burst always completes. A new request made during EXIT is served after the return to IDLE (minimum one IDLE cycle).
- Timing value 0 is treated as 1. Timing value 2^g_tcnt_bits-1 gives the maximum length; the counter does not wrap.
- Reset asserted mid-burst immediately forces the reset outputs. No trail is emitted.
- LP and HS drivers never overlap: hs_tq_o=0 implies lp_oe_n_o=1 in every cycle.

Decomposition:
- Package dsi_dphy_pkg holds:
  - the state enum (IDLE, LPX, PREP, ZERO, SYNC, DATA, TRAIL, EXIT);
  - the LP code constants LP11, LP01, LP00;
  - the default sync byte;
  - a function that builds the sync word for a given g_bytes.
- One sub-module, dphy_lane_timer: a loadable down-counter (load value, load strobe, expired flag) of width g_tcnt_bits, clamping 0 to 1.

Test Plan:
- Reset, g_bytes=1: hold rst_a_i → outputs LP-11, hs_tq_o=1, busy_o=0. Assert rst_a_i mid-DATA → LP-11 within the same cycle (asynchronous); no TRAIL cycles.
- Nominal burst, g_bytes=1, t_lpx=3, prep=2, zero=4, trail=2, exit=3; 3 words A5, 3C, 81 → 3 cycles LP-01, 2 LP-00, 4 of 00, one of B8, then A5, 3C, 81. The 2 trail words are 00 (MSB of 81 is 1), followed by 3 LP-11 cycles. hs_ready_o is high for exactly 3 cycles.
- Zero-length burst: hs_req_i is a single-cycle pulse → full preamble and SYNC B8, then 2 trail words of 00 (MSB of B8 is 1), exit, IDLE. hs_ready_o is never asserted.
- Wide word, g_bytes=2: SYNC = 16'hB800; payload 0x7FFF → trail words FFFF.
- Timing corner cases: all t=0 → each state lasts 1 cycle. All t=255 → 255 cycles each. Change t_lpx during a burst → no effect until the next burst.
- Back-to-back requests: hs_req_i re-asserted during EXIT → at least one IDLE cycle, then LPX starts. Check on every cycle that hs_tq_o=0 never coincides with lp_oe_n_o=0.

Source files
------------

// File: rtl/dsi_dphy_pkg.sv
// Shared types and constants for the D-PHY lane transmit sequencer.
// The LP line codes are packed as {p, n}.
package dsi_dphy_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLpx,
        StPrep,
        StZero,
        StSync,
        StData,
        StTrail,
        StExit
    } dphy_state_e;

    localparam logic [1:0] Lp11 = 2'b11;
    localparam logic [1:0] Lp01 = 2'b01;
    localparam logic [1:0] Lp00 = 2'b00;

    localparam logic [7:0] SyncByteDefault = 8'hB8;

    // The sync byte sits in the last-transmitted byte lane; lower lanes stay 0 as extra HS-zero.
    function automatic logic [31:0] build_sync_word(input int unsigned bytes,
                                                    input logic [7:0] sync);
        return {24'd0, sync} << (8 * (bytes - 1));
    endfunction

endpackage

// File: rtl/dphy_lane_timer.sv
// Loadable down-counter for D-PHY state durations.
// A load of N (0 treated as 1) makes expired_o high after N cycles, counting the load cycle's successor.
module dphy_lane_timer #(
    parameter int unsigned g_tcnt_bits = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  logic [g_tcnt_bits-1:0] val_i,
    output logic                   expired_o
);

    localparam logic [g_tcnt_bits-1:0] One = {{(g_tcnt_bits - 1){1'b0}}, 1'b1};

    logic [g_tcnt_bits-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (val_i == '0) ? '0 : val_i - One;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - One;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/dphy_lane_tx_seq.sv
// Per-lane D-PHY HS burst sequencer: LP-11 -> LP-01 -> LP-00 -> HS-zero -> SYNC -> payload
// -> HS-trail -> LP-11. All outputs are registered from the next state.
module dphy_lane_tx_seq
    import dsi_dphy_pkg::*;
#(
    parameter int unsigned g_bytes     = 1,
    parameter int unsigned g_tcnt_bits = 8,
    parameter logic [7:0]  g_sync      = SyncByteDefault
) (
    input  logic                   clk_word_i,
    input  logic                   rst_a_i,
    input  logic                   hs_req_i,
    input  logic [8*g_bytes-1:0]   data_i,
    output logic                   hs_ready_o,
    output logic                   busy_o,
    input  logic [g_tcnt_bits-1:0] t_lpx_i,
    input  logic [g_tcnt_bits-1:0] t_hs_prep_i,
    input  logic [g_tcnt_bits-1:0] t_hs_zero_i,
    input  logic [g_tcnt_bits-1:0] t_hs_trail_i,
    input  logic [g_tcnt_bits-1:0] t_hs_exit_i,
    output logic [8*g_bytes-1:0]   serdes_d_o,
    output logic                   hs_tq_o,
    output logic                   lp_oe_n_o,
    output logic                   lp_p_o,
    output logic                   lp_n_o
);

    localparam int unsigned W = 8 * g_bytes;
    localparam logic [W-1:0] SyncWord = W'(build_sync_word(g_bytes, g_sync));

    dphy_state_e state_q, state_d;

    logic [g_tcnt_bits-1:0] t_prep_q, t_zero_q, t_trail_q, t_exit_q;
    logic                   tmr_load;
    logic [g_tcnt_bits-1:0] tmr_val;
    logic                   tmr_expired;

    dphy_lane_timer #(
        .g_tcnt_bits (g_tcnt_bits)
    ) u_timer (
        .clk_i     (clk_word_i),
        .rst_i     (rst_a_i),
        .load_i    (tmr_load),
        .val_i     (tmr_val),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = t_lpx_i;
        unique case (state_q)
            StIdle: begin
                if (hs_req_i) begin
                    state_d  = StLpx;
                    tmr_load = 1'b1;
                    tmr_val  = t_lpx_i;
                end
            end
            StLpx: begin
                if (tmr_expired) begin
                    state_d  = StPrep;
                    tmr_load = 1'b1;
                    tmr_val  = t_prep_q;
                end
            end
            StPrep: begin
                if (tmr_expired) begin
                    state_d  = StZero;
                    tmr_load = 1'b1;
                    tmr_val  = t_zero_q;
                end
            end
            StZero: begin
                if (tmr_expired) begin
                    state_d = StSync;
                end
            end
            StSync, StData: begin
                if (hs_req_i) begin
                    state_d = StData;
                end else begin
                    state_d  = StTrail;
                    tmr_load = 1'b1;
                    tmr_val  = t_trail_q;
                end
            end
            StTrail: begin
                if (tmr_expired) begin
                    state_d  = StExit;
                    tmr_load = 1'b1;
                    tmr_val  = t_exit_q;
                end
            end
            StExit: begin
                if (tmr_expired) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_word_i or posedge rst_a_i) begin
        if (rst_a_i) begin
            state_q    <= StIdle;
            t_prep_q   <= '0;
            t_zero_q   <= '0;
            t_trail_q  <= '0;
            t_exit_q   <= '0;
            serdes_d_o <= '0;
            hs_tq_o    <= 1'b1;
            lp_oe_n_o  <= 1'b0;
            lp_p_o     <= 1'b1;
            lp_n_o     <= 1'b1;
            hs_ready_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            state_q <= state_d;
            // Timings are frozen for the whole burst at the moment IDLE is left.
            if (state_q == StIdle && hs_req_i) begin
                t_prep_q  <= t_hs_prep_i;
                t_zero_q  <= t_hs_zero_i;
                t_trail_q <= t_hs_trail_i;
                t_exit_q  <= t_hs_exit_i;
            end
            busy_o     <= (state_d != StIdle);
            hs_ready_o <= (state_d == StData);
            case (state_d)
                StLpx: begin
                    serdes_d_o         <= '0;
                    hs_tq_o            <= 1'b1;
                    lp_oe_n_o          <= 1'b0;
                    {lp_p_o, lp_n_o}   <= Lp01;
                end
                StPrep: begin
                    serdes_d_o         <= '0;
                    hs_tq_o            <= 1'b1;
                    lp_oe_n_o          <= 1'b0;
                    {lp_p_o, lp_n_o}   <= Lp00;
                end
                StZero: begin
                    serdes_d_o         <= '0;
                    hs_tq_o            <= 1'b0;
                    lp_oe_n_o          <= 1'b1;
                    {lp_p_o, lp_n_o}   <= Lp00;
                end
                StSync: begin
                    serdes_d_o         <= SyncWord;
                    hs_tq_o            <= 1'b0;
                    lp_oe_n_o          <= 1'b1;
                    {lp_p_o, lp_n_o}   <= Lp00;
                end
                StData: begin
                    serdes_d_o         <= data_i;
                    hs_tq_o            <= 1'b0;
                    lp_oe_n_o          <= 1'b1;
                    {lp_p_o, lp_n_o}   <= Lp00;
                end
                StTrail: begin
                    // On entry serdes_d_o still holds the last SYNC/DATA word.
                    if (state_q != StTrail) begin
                        serdes_d_o <= {W{~serdes_d_o[W-1]}};
                    end
                    hs_tq_o            <= 1'b0;
                    lp_oe_n_o          <= 1'b1;
                    {lp_p_o, lp_n_o}   <= Lp00;
                end
                default: begin
                    serdes_d_o         <= '0;
                    hs_tq_o            <= 1'b1;
                    lp_oe_n_o          <= 1'b0;
                    {lp_p_o, lp_n_o}   <= Lp11;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dphy_lane_tx_seq.sv
// Randomized bench for dphy_lane_tx_seq with 1-byte and 2-byte lanes side by side.
// Each burst is expanded into a per-cycle stimulus/expected timeline from the line-state rules.
module tb_dphy_lane_tx_seq;

    logic        clk_word = 1'b0;
    logic        rst_a    = 1'b1;
    logic        hs_req   = 1'b0;
    logic [15:0] data     = '0;
    logic [7:0]  t_lpx    = '0;
    logic [7:0]  t_prep   = '0;
    logic [7:0]  t_zero   = '0;
    logic [7:0]  t_trail  = '0;
    logic [7:0]  t_exit   = '0;

    logic [7:0]  d8;
    logic        rdy8, busy8, tq8, oe8, p8, n8;
    logic [15:0] d16;
    logic        rdy16, busy16, tq16, oe16, p16, n16;

    always #5 clk_word = ~clk_word;

    dphy_lane_tx_seq #(
        .g_bytes     (1),
        .g_tcnt_bits (8),
        .g_sync      (8'hB8)
    ) u_dut8 (
        .clk_word_i   (clk_word),
        .rst_a_i      (rst_a),
        .hs_req_i     (hs_req),
        .data_i       (data[7:0]),
        .hs_ready_o   (rdy8),
        .busy_o       (busy8),
        .t_lpx_i      (t_lpx),
        .t_hs_prep_i  (t_prep),
        .t_hs_zero_i  (t_zero),
        .t_hs_trail_i (t_trail),
        .t_hs_exit_i  (t_exit),
        .serdes_d_o   (d8),
        .hs_tq_o      (tq8),
        .lp_oe_n_o    (oe8),
        .lp_p_o       (p8),
        .lp_n_o       (n8)
    );

    dphy_lane_tx_seq #(
        .g_bytes     (2),
        .g_tcnt_bits (8),
        .g_sync      (8'hB8)
    ) u_dut16 (
        .clk_word_i   (clk_word),
        .rst_a_i      (rst_a),
        .hs_req_i     (hs_req),
        .data_i       (data),
        .hs_ready_o   (rdy16),
        .busy_o       (busy16),
        .t_lpx_i      (t_lpx),
        .t_hs_prep_i  (t_prep),
        .t_hs_zero_i  (t_zero),
        .t_hs_trail_i (t_trail),
        .t_hs_exit_i  (t_exit),
        .serdes_d_o   (d16),
        .hs_tq_o      (tq16),
        .lp_oe_n_o    (oe16),
        .lp_p_o       (p16),
        .lp_n_o       (n16)
    );

    typedef struct packed {
        logic        oe_n;
        logic        p;
        logic        n;
        logic        tq;
        logic        ready;
        logic        busy;
        logic [7:0]  d8;
        logic [15:0] d16;
    } exp_t;

    logic        q_req[$];
    logic [15:0] q_dat[$];
    logic [39:0] q_t[$];
    exp_t        q_exp[$];
    logic [15:0] wq[$];

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic oe_n, input logic p, input logic n, input logic tq,
                                input logic ready, input logic busy, input logic [7:0] e8,
                                input logic [15:0] e16);
        exp_t e;
        e.oe_n  = oe_n;
        e.p     = p;
        e.n     = n;
        e.tq    = tq;
        e.ready = ready;
        e.busy  = busy;
        e.d8    = e8;
        e.d16   = e16;
        return e;
    endfunction

    function automatic int unsigned dur(input logic [7:0] t);
        return (t == 8'd0) ? 1 : {24'd0, t};
    endfunction

    function automatic logic [39:0] rnd_t();
        logic [39:0] v;
        v[31:0]  = $urandom();
        v[39:32] = 8'($urandom());
        return v;
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic mode_bit(input int mode);
        return (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : rnd_bit();
    endfunction

    task automatic add(input logic req, input logic [15:0] d, input logic [39:0] t, input exp_t e);
        q_req.push_back(req);
        q_dat.push_back(d);
        q_t.push_back(t);
        q_exp.push_back(e);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) begin
            add(1'b0, 16'($urandom()), rnd_t(), mk(0, 1, 1, 1, 0, 0, 8'h00, 16'h0000));
        end
    endtask

    // t = {lpx, prep, zero, trail, exit}; words come from wq. Modes: 0 low, 1 high, 2 random.
    task automatic plan_burst(input int gap, input logic [39:0] t, input int pre_mode,
                              input int exit_mode);
        int          nw;
        int unsigned n1, n2, n3, n4, n5;
        logic [7:0]  last8;
        logic [15:0] last16;
        nw = wq.size();
        n1 = dur(t[39:32]);
        n2 = dur(t[31:24]);
        n3 = dur(t[23:16]);
        n4 = dur(t[15:8]);
        n5 = dur(t[7:0]);
        add_idle(gap);
        add(1'b1, 16'($urandom()), t, mk(0, 1, 1, 1, 0, 0, 8'h00, 16'h0000));
        for (int i = 0; i < int'(n1); i++)
            add(mode_bit(pre_mode), 16'($urandom()), rnd_t(), mk(0, 0, 1, 1, 0, 1, 8'h00, 16'h0));
        for (int i = 0; i < int'(n2); i++)
            add(mode_bit(pre_mode), 16'($urandom()), rnd_t(), mk(0, 0, 0, 1, 0, 1, 8'h00, 16'h0));
        for (int i = 0; i < int'(n3); i++)
            add(mode_bit(pre_mode), 16'($urandom()), rnd_t(), mk(1, 0, 0, 0, 0, 1, 8'h00, 16'h0));
        add(nw > 0, (nw > 0) ? wq[0] : 16'($urandom()), rnd_t(),
            mk(1, 0, 0, 0, 0, 1, 8'hB8, 16'hB800));
        last8  = 8'hB8;
        last16 = 16'hB800;
        for (int i = 0; i < nw; i++) begin
            add(i < nw - 1, (i < nw - 1) ? wq[i+1] : 16'($urandom()), rnd_t(),
                mk(1, 0, 0, 0, 1, 1, wq[i][7:0], wq[i]));
            last8  = wq[i][7:0];
            last16 = wq[i];
        end
        for (int i = 0; i < int'(n4); i++)
            add(rnd_bit(), 16'($urandom()), rnd_t(),
                mk(1, 0, 0, 0, 0, 1, {8{~last8[7]}}, {16{~last16[15]}}));
        for (int i = 0; i < int'(n5); i++)
            add(mode_bit(exit_mode), 16'($urandom()), rnd_t(), mk(0, 1, 1, 1, 0, 1, 8'h00, 16'h0));
        wq.delete();
    endtask

    task automatic run_plan(input int stop);
        int   n;
        exp_t e;
        n = (stop < q_exp.size()) ? stop : q_exp.size();
        for (int c = 0; c < n; c++) begin
            @(posedge clk_word);
            #1;
            e = q_exp[c];
            check_val($sformatf("ctl8@%0d", c), 32'({oe8, tq8, rdy8, busy8}),
                      32'({e.oe_n, e.tq, e.ready, e.busy}));
            check_val($sformatf("ctl16@%0d", c), 32'({oe16, tq16, rdy16, busy16}),
                      32'({e.oe_n, e.tq, e.ready, e.busy}));
            if (!e.oe_n) begin
                check_val($sformatf("lp8@%0d", c), 32'({p8, n8}), 32'({e.p, e.n}));
                check_val($sformatf("lp16@%0d", c), 32'({p16, n16}), 32'({e.p, e.n}));
            end
            check_val($sformatf("d8@%0d", c), 32'(d8), 32'(e.d8));
            check_val($sformatf("d16@%0d", c), 32'(d16), 32'(e.d16));
            hs_req = q_req[c];
            data   = q_dat[c];
            {t_lpx, t_prep, t_zero, t_trail, t_exit} = q_t[c];
        end
    endtask

    task automatic clear_plan();
        q_req.delete();
        q_dat.delete();
        q_t.delete();
        q_exp.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ctl8"}, 32'({oe8, tq8, rdy8, busy8, p8, n8}), 32'(6'b010011));
        check_val({tag, "_ctl16"}, 32'({oe16, tq16, rdy16, busy16, p16, n16}), 32'(6'b010011));
        check_val({tag, "_d8"}, 32'(d8), 32'd0);
        check_val({tag, "_d16"}, 32'(d16), 32'd0);
    endtask

    // HS driver enabled together with LP drivers is never allowed.
    always @(negedge clk_word) begin
        if (!rst_a) begin
            check_val("no_overlap8", 32'(tq8 | oe8), 32'd1);
            check_val("no_overlap16", 32'(tq16 | oe16), 32'd1);
        end
    end

    initial begin
        logic [39:0] t;
        int          nw;
        #12;
        check_reset_outputs("reset_hold");
        #6;
        rst_a = 1'b0;

        wq = '{16'h12A5, 16'h343C, 16'h5681};
        plan_burst(1, {8'd3, 8'd2, 8'd4, 8'd2, 8'd3}, 2, 0);
        plan_burst(2, {8'd3, 8'd2, 8'd4, 8'd2, 8'd3}, 0, 0);
        wq = '{16'h7FFF};
        plan_burst(0, {8'd1, 8'd3, 8'd2, 8'd3, 8'd4}, 1, 1);
        wq = '{16'h0001, 16'h8000};
        plan_burst(0, 40'd0, 2, 2);
        wq = '{16'hBEEF};
        plan_burst(1, {5{8'hFF}}, 2, 2);
        for (int b = 0; b < 16; b++) begin
            nw = $urandom_range(0, 6);
            for (int i = 0; i < nw; i++) wq.push_back(16'($urandom()));
            for (int f = 0; f < 5; f++) begin
                t[8*f +: 8] = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 5));
            end
            plan_burst($urandom_range(0, 3), t, $urandom_range(0, 2), $urandom_range(0, 2));
        end
        add_idle(3);
        run_plan(q_exp.size());
        clear_plan();

        // Reset in the middle of DATA: cycles 5.. are DATA with all timings 0.
        wq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        plan_burst(0, 40'd0, 0, 0);
        add_idle(2);
        run_plan(7);
        #2;
        rst_a = 1'b1;
        #1;
        check_reset_outputs("reset_async");
        @(posedge clk_word);
        #1;
        hs_req = 1'b0;
        rst_a  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk_word);
            #1;
            check_reset_outputs($sformatf("post_reset%0d", c));
        end
        clear_plan();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
